// File: rtl/jtdd2_snd_pkg.sv
// Shared types for the sound ROM arbiter.
// FSM states, grant encoding and default SDRAM word offsets.
package jtdd2_snd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    typedef enum logic {
        GNT_CPU,
        GNT_PCM
    } gnt_t;

    localparam logic [21:0] CPU_OFFS_DEF = 22'h0;
    localparam logic [21:0] PCM_OFFS_DEF = 22'h4000;

endpackage

// File: rtl/jtdd2_romarb_cache.sv
// One-word tag cache for a byte-addressed ROM requester.
// Hit is combinational; a fill writes word, tag and valid.
module jtdd2_romarb_cache #(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          fill,
    input  logic [AW-2:0] fill_tag,
    input  logic [15:0]   fill_data,
    output logic          ok,
    output logic [7:0]    data,
    output logic          miss
);

    logic          valid;
    logic [AW-2:0] tag;
    logic [15:0]   word;
    logic          hit;

    assign hit  = cs & valid & (addr[AW-1:1] == tag);
    assign ok   = hit;
    assign miss = cs & ~hit;
    assign data = hit ? (addr[0] ? word[15:8] : word[7:0]) : 8'h00;

    // Capture the fetched word when the arbiter completes a fill for us
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            word  <= '0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            word  <= fill_data;
        end
    end

endmodule

// File: rtl/jtdd2_snd_romarb.sv
// Sound CPU / ADPCM ROM arbiter sharing one SDRAM read slot.
// Define JTDD2_ROMARB_RR_EN for round-robin instead of CPU priority.
module jtdd2_snd_romarb
    import jtdd2_snd_pkg::*;
#(
    parameter int                  CPU_AW   = 15,
    parameter int                  PCM_AW   = 18,
    parameter int                  SDRAM_AW = 22,
    parameter logic [SDRAM_AW-1:0] CPU_OFFS = SDRAM_AW'(CPU_OFFS_DEF),
    parameter logic [SDRAM_AW-1:0] PCM_OFFS = SDRAM_AW'(PCM_OFFS_DEF)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_cs,
    input  logic [CPU_AW-1:0]   cpu_addr,
    output logic [7:0]          cpu_data,
    output logic                cpu_ok,
    input  logic                pcm_cs,
    input  logic [PCM_AW-1:0]   pcm_addr,
    output logic [7:0]          pcm_data,
    output logic                pcm_ok,
    output logic                sdram_req,
    output logic [SDRAM_AW-1:0] sdram_addr,
    input  logic                sdram_ack,
    input  logic                sdram_dok,
    input  logic [15:0]         sdram_data
);

    localparam int TW = (CPU_AW > PCM_AW ? CPU_AW : PCM_AW) - 1;

    state_t              state;
    gnt_t                grant;
    gnt_t                pick;
    logic [TW-1:0]       ftag;
    logic                cpu_miss;
    logic                pcm_miss;
    logic                cpu_fill;
    logic                pcm_fill;
    logic [SDRAM_AW-1:0] cpu_wa;
    logic [SDRAM_AW-1:0] pcm_wa;

    assign cpu_wa   = CPU_OFFS + SDRAM_AW'(cpu_addr[CPU_AW-1:1]);
    assign pcm_wa   = PCM_OFFS + SDRAM_AW'(pcm_addr[PCM_AW-1:1]);
    assign cpu_fill = (state == WAIT) & sdram_dok & (grant == GNT_CPU);
    assign pcm_fill = (state == WAIT) & sdram_dok & (grant == GNT_PCM);

    jtdd2_romarb_cache #(.AW(CPU_AW)) u_cpu (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cpu_cs),
        .addr      (cpu_addr),
        .fill      (cpu_fill),
        .fill_tag  (ftag[CPU_AW-2:0]),
        .fill_data (sdram_data),
        .ok        (cpu_ok),
        .data      (cpu_data),
        .miss      (cpu_miss)
    );

    jtdd2_romarb_cache #(.AW(PCM_AW)) u_pcm (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (pcm_cs),
        .addr      (pcm_addr),
        .fill      (pcm_fill),
        .fill_tag  (ftag[PCM_AW-2:0]),
        .fill_data (sdram_data),
        .ok        (pcm_ok),
        .data      (pcm_data),
        .miss      (pcm_miss)
    );

`ifdef JTDD2_ROMARB_RR_EN
    gnt_t last;

    // On a tie the requester served last time yields
    always_comb begin
        pick = cpu_miss ? GNT_CPU : GNT_PCM;
        if (cpu_miss && pcm_miss && last == GNT_CPU)
            pick = GNT_PCM;
    end

    // Remember who won the most recent arbitration
    always_ff @(posedge clk) begin
        if (!rst_n)
            last <= GNT_PCM;
        else if (state == IDLE && (cpu_miss || pcm_miss))
            last <= pick;
    end
`else
    // CPU always wins when both miss
    always_comb begin
        pick = cpu_miss ? GNT_CPU : GNT_PCM;
    end
`endif

    // Fetch sequencer: arbitrate in IDLE, hold req until ack, fill on dok
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= GNT_CPU;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_miss || pcm_miss) begin
                        grant     <= pick;
                        sdram_req <= 1'b1;
                        state     <= REQ;
                        if (pick == GNT_CPU) begin
                            sdram_addr <= cpu_wa;
                            ftag       <= TW'(cpu_addr[CPU_AW-1:1]);
                        end else begin
                            sdram_addr <= pcm_wa;
                            ftag       <= TW'(pcm_addr[PCM_AW-1:1]);
                        end
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (sdram_dok)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtdd2_snd_romarb.sv
// Scoreboard bench for jtdd2_snd_romarb with an SDRAM responder model.
// Define JTDD2_ROMARB_RR_EN to also exercise round-robin alternation.
module tb_jtdd2_snd_romarb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_cs = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic [7:0]  cpu_data;
    logic        cpu_ok;
    logic        pcm_cs = 1'b0;
    logic [17:0] pcm_addr = '0;
    logic [7:0]  pcm_data;
    logic        pcm_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        sdram_dok;
    logic [15:0] sdram_data;

    logic        model_en = 1'b1;
    logic        m_ack = 1'b0;
    logic        m_dok = 1'b0;
    logic [15:0] m_data = '0;
    logic        man_ack = 1'b0;
    logic        man_dok = 1'b0;
    logic [15:0] man_data = '0;

    assign sdram_ack  = model_en ? m_ack  : man_ack;
    assign sdram_dok  = model_en ? m_dok  : man_dok;
    assign sdram_data = model_en ? m_data : man_data;

    always #5 clk = ~clk;

    jtdd2_snd_romarb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_cs     (cpu_cs),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_ok     (cpu_ok),
        .pcm_cs     (pcm_cs),
        .pcm_addr   (pcm_addr),
        .pcm_data   (pcm_data),
        .pcm_ok     (pcm_ok),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_dok  (sdram_dok),
        .sdram_data (sdram_data)
    );

    typedef struct {
        logic [17:0] addr;
        logic [7:0]  data;
    } okx_t;

    okx_t        cpu_q[$];
    okx_t        pcm_q[$];
    logic [21:0] req_q[$];
    logic [15:0] mem[int];

    int n_cmp = 0;
    int n_err = 0;
    int req_n = 0;
    int exp_req_n = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [21:0] a);
        req_q.push_back(a);
        exp_req_n++;
    endtask

    function automatic logic [15:0] mem_rd(input logic [21:0] a);
        if (mem.exists(int'(a)))
            return mem[int'(a)];
        return 16'hDEAD;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((cpu_q.size() + pcm_q.size() + req_q.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(name, 32'(cpu_q.size() + pcm_q.size() + req_q.size()), 32'h0);
    endtask

    // SDRAM responder: ack one cycle after req, dok the cycle after
    initial begin
        logic        dok_pend;
        logic [21:0] lat;
        dok_pend = 1'b0;
        lat = '0;
        forever begin
            @(posedge clk);
            #1;
            m_ack = 1'b0;
            m_dok = 1'b0;
            if (model_en) begin
                if (dok_pend) begin
                    m_dok = 1'b1;
                    m_data = mem_rd(lat);
                    dok_pend = 1'b0;
                end else if (sdram_req) begin
                    m_ack = 1'b1;
                    lat = sdram_addr;
                    dok_pend = 1'b1;
                end
            end
        end
    end

    // Monitor: pop expectations on new requests and new ok presentations
    initial begin
        logic        pr;
        logic        pc;
        logic        pp;
        logic [14:0] pca;
        logic [17:0] ppa;
        okx_t        e;
        logic [21:0] ea;
        pr = 1'b0;
        pc = 1'b0;
        pp = 1'b0;
        pca = '0;
        ppa = '0;
        forever begin
            @(negedge clk);
            if (sdram_req && !pr) begin
                req_n++;
                if (req_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL req_unexp: got addr %h expected none", sdram_addr);
                end else begin
                    ea = req_q.pop_front();
                    chk("req_addr", 32'(sdram_addr), 32'(ea));
                end
            end
            if (cpu_ok && (!pc || cpu_addr != pca)) begin
                if (cpu_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL cpu_ok_unexp: got ok at %h expected none", cpu_addr);
                end else begin
                    e = cpu_q.pop_front();
                    chk("cpu_ok_addr", 32'(cpu_addr), 32'(e.addr));
                    chk("cpu_data", 32'(cpu_data), 32'(e.data));
                end
            end
            if (pcm_ok && (!pp || pcm_addr != ppa)) begin
                if (pcm_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pcm_ok_unexp: got ok at %h expected none", pcm_addr);
                end else begin
                    e = pcm_q.pop_front();
                    chk("pcm_ok_addr", 32'(pcm_addr), 32'(e.addr));
                    chk("pcm_data", 32'(pcm_data), 32'(e.data));
                end
            end
            pr = sdram_req;
            pc = cpu_ok;
            pp = pcm_ok;
            pca = cpu_addr;
            ppa = pcm_addr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        int n;
        int r0;

        mem[32'h8]    = 16'hBEEF;
        mem[32'h4001] = 16'h1234;
        mem[32'h20]   = 16'hA55A;
        mem[32'h4008] = 16'h7788;
        mem[32'h10]   = 16'hC0DE;
        mem[32'h80]   = 16'h1357;
        mem[32'h100]  = 16'h1111;
        mem[32'h101]  = 16'h2222;
        mem[32'h4100] = 16'h3333;
        mem[32'h4101] = 16'h4444;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cpu_ok", 32'(cpu_ok), 32'h0);
        chk("rst_pcm_ok", 32'(pcm_ok), 32'h0);
        chk("rst_cpu_data", 32'(cpu_data), 32'h0);
        chk("rst_req", 32'(sdram_req), 32'h0);
        chk("rst_addr", 32'(sdram_addr), 32'h0);

        // 1: CPU miss, then hit on the other byte of the same word
        @(posedge clk);
        #1;
        push_req(22'h8);
        cpu_q.push_back('{18'h10, 8'hEF});
        cpu_addr = 15'h0010;
        cpu_cs = 1'b1;
        n = 0;
        while (!cpu_ok && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("t1_latency", 32'(n), 32'd3);
        @(posedge clk);
        #1;
        cpu_q.push_back('{18'h11, 8'hBE});
        cpu_addr = 15'h0011;
        repeat (4) @(negedge clk);
        chk("t1_req_cnt", 32'(req_n), 32'(exp_req_n));
        drain("t1_drain");
        @(posedge clk);
        #1 cpu_cs = 1'b0;

        // 2: ADPCM miss with offset
        @(posedge clk);
        #1;
        push_req(22'h4001);
        pcm_q.push_back('{18'h2, 8'h34});
        pcm_addr = 18'h00002;
        pcm_cs = 1'b1;
        drain("t2_drain");
        @(posedge clk);
        #1 pcm_cs = 1'b0;

        // 3: simultaneous miss, CPU first
        @(posedge clk);
        #1;
        r0 = req_n;
        push_req(22'h20);
        push_req(22'h4008);
        cpu_q.push_back('{18'h40, 8'h5A});
        pcm_q.push_back('{18'h10, 8'h88});
        cpu_addr = 15'h0040;
        pcm_addr = 18'h00010;
        cpu_cs = 1'b1;
        pcm_cs = 1'b1;
        drain("t3_drain");
        repeat (3) @(negedge clk);
        chk("t3_two_reqs", 32'(req_n - r0), 32'd2);
        @(posedge clk);
        #1;
        cpu_cs = 1'b0;
        pcm_cs = 1'b0;

        // 4: address change while waiting for data
        @(posedge clk);
        #1;
        push_req(22'h8);
        cpu_addr = 15'h0010;
        cpu_cs = 1'b1;
        n = 0;
        @(negedge clk);
        while (!sdram_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_ack_seen", 32'(sdram_ack), 32'h1);
        @(posedge clk);
        #1;
        push_req(22'h10);
        cpu_q.push_back('{18'h20, 8'hDE});
        cpu_addr = 15'h0020;
        @(negedge clk);
        chk("t4_wait_ok", 32'(cpu_ok), 32'h0);
        @(negedge clk);
        chk("t4_stale_fill_ok", 32'(cpu_ok), 32'h0);
        drain("t4_drain");
        @(posedge clk);
        #1 cpu_cs = 1'b0;

        // 5: reset while waiting, then a stray dok
        @(posedge clk);
        #1;
        model_en = 1'b0;
        push_req(22'h80);
        cpu_addr = 15'h0100;
        cpu_cs = 1'b1;
        n = 0;
        @(negedge clk);
        while (!sdram_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_req_seen", 32'(sdram_req), 32'h1);
        @(posedge clk);
        #1 man_ack = 1'b1;
        @(posedge clk);
        #1;
        man_ack = 1'b0;
        rst_n = 1'b0;
        cpu_cs = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        man_dok = 1'b1;
        man_data = 16'hFFFF;
        @(posedge clk);
        #1 man_dok = 1'b0;
        @(negedge clk);
        chk("t5_req_idle", 32'(sdram_req), 32'h0);
        chk("t5_addr_rst", 32'(sdram_addr), 32'h0);
        @(posedge clk);
        #1;
        model_en = 1'b1;
        push_req(22'h80);
        push_req(22'h4008);
        cpu_q.push_back('{18'h100, 8'h57});
        pcm_q.push_back('{18'h10, 8'h88});
        cpu_addr = 15'h0100;
        pcm_addr = 18'h00010;
        cpu_cs = 1'b1;
        pcm_cs = 1'b1;
        @(negedge clk);
        chk("t5_cpu_inval", 32'(cpu_ok), 32'h0);
        chk("t5_pcm_inval", 32'(pcm_ok), 32'h0);
        drain("t5_drain");
        @(posedge clk);
        #1;
        cpu_cs = 1'b0;
        pcm_cs = 1'b0;

`ifdef JTDD2_ROMARB_RR_EN
        // 6: continuous misses on both sides alternate grants
        @(posedge clk);
        #1;
        push_req(22'h100);
        push_req(22'h4100);
        push_req(22'h101);
        push_req(22'h4101);
        cpu_q.push_back('{18'h200, 8'h11});
        cpu_q.push_back('{18'h202, 8'h22});
        pcm_q.push_back('{18'h200, 8'h33});
        pcm_q.push_back('{18'h202, 8'h44});
        cpu_addr = 15'h0200;
        pcm_addr = 18'h00200;
        cpu_cs = 1'b1;
        pcm_cs = 1'b1;
        n = 0;
        while ((cpu_cs || pcm_cs) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
            if (cpu_ok && cpu_cs) begin
                if (cpu_addr == 15'h0200)
                    cpu_addr = 15'h0202;
                else
                    cpu_cs = 1'b0;
            end
            if (pcm_ok && pcm_cs) begin
                if (pcm_addr == 18'h00200)
                    pcm_addr = 18'h00202;
                else
                    pcm_cs = 1'b0;
            end
        end
        chk("t6_done", 32'(cpu_cs | pcm_cs), 32'h0);
        drain("t6_drain");
`endif

        repeat (4) @(negedge clk);
        chk("final_req_cnt", 32'(req_n), 32'(exp_req_n));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
